// File: rtl/riscv_pkg.sv
// Shared constants and IF/ID control encoding for the RISC-V core pipeline.
// Consumed by if_stage, if_id_reg and the testbench.
package riscv_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_PC_C    = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_C   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFID_CAPTURE = 2'd0,
        IFID_HOLD    = 2'd1,
        IFID_BUBBLE  = 2'd2
    } ifid_act_e;

    // Flush and redirect both squash the fetched word; either beats a decode stall.
    function automatic ifid_act_e ifid_action(input logic flush,
                                              input logic redirect,
                                              input logic stall);
        ifid_act_e act;
        if (flush || redirect) begin
            act = IFID_BUBBLE;
        end else if (stall) begin
            act = IFID_HOLD;
        end else begin
            act = IFID_CAPTURE;
        end
        return act;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures, holds or replaces its contents with a bubble
// (NOP_INSTR at pc 0, marked invalid).
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic            clk,
    input  logic            rstn,
    input  ifid_act_e       act,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D,
    output logic [31:0]     instrD,
    output logic            validD
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    // Next IF/ID contents from the selected action.
    always_comb begin
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        case (act)
            IFID_BUBBLE: begin
                pc_d      = {XLEN{1'b0}};
                pcplus4_d = XLEN'(32'd4);
                instr_d   = NOP_INSTR;
                valid_d   = 1'b0;
            end
            IFID_CAPTURE: begin
                pc_d      = pc_in;
                pcplus4_d = pc_in + XLEN'(32'd4);
                instr_d   = instr_in;
                valid_d   = 1'b1;
            end
            IFID_HOLD: begin
                pc_d      = pc_q;
                pcplus4_d = pcplus4_q;
                instr_d   = instr_q;
                valid_d   = valid_q;
            end
            default: begin
                pc_d      = pc_q;
                pcplus4_d = pcplus4_q;
                instr_d   = instr_q;
                valid_d   = valid_q;
            end
        endcase
    end

    // IF/ID state; reset contents match a bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= {XLEN{1'b0}};
            pcplus4_q <= XLEN'(32'd4);
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

    assign pcD      = pc_q;
    assign pcplus4D = pcplus4_q;
    assign instrD   = instr_q;
    assign validD   = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, redirect/stall handling, IF/ID register and counters.
// Optional IF_MISALIGN_CHK_EN: align redirect targets and flag misaligned ones (sticky).
module if_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_C),
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_C
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] im_addr,
    input  logic [31:0]     im_rdata,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D,
    output logic [31:0]     instrD,
    output logic            validD,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     bubble_cnt,
    output logic            misalign_err
);

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] redirect_tgt_s;
    logic            misalign_q, misalign_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic [31:0]     bubble_cnt_q, bubble_cnt_d;
    ifid_act_e       ifid_act_s;

`ifdef IF_MISALIGN_CHK_EN
    // Redirect target is word-aligned; a misaligned request latches the error.
    always_comb begin
        redirect_tgt_s = {redirect_pc[XLEN-1:2], 2'b00};
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
    end
`else
    assign redirect_tgt_s = redirect_pc;
    assign misalign_d     = 1'b0;
`endif

    // Next fetch PC: redirect beats stall; sequential fetch wraps at XLEN bits.
    always_comb begin
        pcf_d = pcf_q;
        if (redirect_valid) begin
            pcf_d = redirect_tgt_s;
        end else if (stallF) begin
            pcf_d = pcf_q;
        end else begin
            pcf_d = pcf_q + XLEN'(32'd4);
        end
    end

    assign ifid_act_s = ifid_action(flushD, redirect_valid, stallD);

    // Fetch/bubble counters step once per IF/ID update of the matching kind.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        case (ifid_act_s)
            IFID_BUBBLE:  bubble_cnt_d = bubble_cnt_q + 32'd1;
            IFID_CAPTURE: fetch_cnt_d  = fetch_cnt_q + 32'd1;
            IFID_HOLD: begin
                fetch_cnt_d  = fetch_cnt_q;
                bubble_cnt_d = bubble_cnt_q;
            end
            default: begin
                fetch_cnt_d  = fetch_cnt_q;
                bubble_cnt_d = bubble_cnt_q;
            end
        endcase
    end

    // Fetch PC, counters and sticky error state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcf_q        <= RESET_PC;
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
            misalign_q   <= 1'b0;
        end else begin
            pcf_q        <= pcf_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            misalign_q   <= misalign_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rstn     (rstn),
        .act      (ifid_act_s),
        .pc_in    (pcf_q),
        .instr_in (im_rdata),
        .pcD      (pcD),
        .pcplus4D (pcplus4D),
        .instrD   (instrD),
        .validD   (validD)
    );

    assign im_addr      = pcf_q;
    assign fetch_cnt    = fetch_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control
// checked against a behavioural fetch model.
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] im_addr, im_rdata, pcD, pcplus4D, instrD, fetch_cnt, bubble_cnt;
    logic        validD, misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc, m_pcD, m_pcp4D, m_instrD, m_fc, m_bc;
    logic        m_validD, m_err;

    if_stage dut (
        .clk(clk), .rstn(rstn), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .im_addr(im_addr),
        .im_rdata(im_rdata), .pcD(pcD), .pcplus4D(pcplus4D), .instrD(instrD),
        .validD(validD), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign im_rdata = rom_word(im_addr);

    function automatic logic [193:0] dut_vec();
        return {im_addr, pcD, pcplus4D, instrD, validD, fetch_cnt, bubble_cnt, misalign_err};
    endfunction

    function automatic logic [193:0] model_vec();
        return {m_pc, m_pcD, m_pcp4D, m_instrD, m_validD, m_fc, m_bc, m_err};
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC_C; m_pcD = 32'd0; m_pcp4D = 32'd4; m_instrD = NOP_INSTR_C;
        m_validD = 1'b0; m_fc = 32'd0; m_bc = 32'd0; m_err = 1'b0;
    endtask

    // One clock of the architectural rules, using the pre-edge fetch PC.
    task automatic model_step();
        if (flushD || redirect_valid) begin
            m_instrD = NOP_INSTR_C; m_validD = 1'b0; m_pcD = 32'd0; m_pcp4D = 32'd4;
            m_bc = m_bc + 32'd1;
        end else if (!stallD) begin
            m_instrD = rom_word(m_pc); m_pcD = m_pc; m_pcp4D = m_pc + 32'd4;
            m_validD = 1'b1; m_fc = m_fc + 32'd1;
        end
        if (redirect_valid) begin
`ifdef IF_MISALIGN_CHK_EN
            if (redirect_pc % 4 != 0) m_err = 1'b1;
            m_pc = redirect_pc - (redirect_pc % 4);
`else
            m_pc = redirect_pc;
`endif
        end else if (!stallF) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd,
                         input logic rv, input logic [31:0] rp);
        stallF = sf; stallD = sd; flushD = fd; redirect_valid = rv; redirect_pc = rp;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (dut_vec() !== {32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", dut_vec(),
                     {32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 32'h0, 32'h0, 1'b0});
        end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (im_addr !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL free_run_addr[%0d]: got %h want %h", i, im_addr, 32'(i * 4));
            end
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL free_run[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if ({fetch_cnt, instrD, validD} !== {32'd5, 32'h1000_0004, 1'b1}) begin
            n_fail++;
            $display("FAIL free_run_end: got %h want %h", {fetch_cnt, instrD, validD},
                     {32'd5, 32'h1000_0004, 1'b1});
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({im_addr, instrD, fetch_cnt, bubble_cnt} !== {32'h8, 32'h1000_0001, 32'd2, 32'd0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i,
                         {im_addr, instrD, fetch_cnt, bubble_cnt}, {32'h8, 32'h1000_0001, 32'd2, 32'd0});
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_tests++;
        if ({im_addr, instrD} !== {32'hC, 32'h1000_0002} || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL stall_resume: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        tick();
        n_tests++;
        if ({im_addr, instrD, validD, bubble_cnt} !== {32'h40, 32'h13, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL redirect: got %h want %h", {im_addr, instrD, validD, bubble_cnt},
                     {32'h40, 32'h13, 1'b0, 32'd1});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_tests++;
        if ({pcD, instrD} !== {32'h40, 32'h1000_0010} || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL redirect_target: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_flush();
        do_reset();
        tick(); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        n_tests++;
        if ({im_addr, validD, instrD, bubble_cnt} !== {32'hC, 1'b0, 32'h13, 32'd1}) begin
            n_fail++;
            $display("FAIL flush_wins: got %h want %h", {im_addr, validD, instrD, bubble_cnt},
                     {32'hC, 1'b0, 32'h13, 32'd1});
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        n_tests++;
        if ({im_addr, bubble_cnt, fetch_cnt} !== {32'hC, 32'd2, 32'd2} || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL flush_stallF: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_tests++;
        if ({im_addr, pcD, pcplus4D} !== {32'h0, 32'hFFFF_FFFC, 32'h0} || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL wrap: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_err;
`ifdef IF_MISALIGN_CHK_EN
        exp_pc = 32'h44; exp_err = 1'b1;
`else
        exp_pc = 32'h46; exp_err = 1'b0;
`endif
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h46);
        tick();
        n_tests++;
        if ({im_addr, misalign_err, validD} !== {exp_pc, exp_err, 1'b0}) begin
            n_fail++;
            $display("FAIL misalign: got %h want %h", {im_addr, misalign_err, validD}, {exp_pc, exp_err, 1'b0});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); tick();
        n_tests++;
        if (misalign_err !== exp_err || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL misalign_sticky: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (dut_vec() !== {32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", dut_vec(),
                     {32'h0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 32'h0, 32'h0, 1'b0});
        end
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] rp;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rp = $urandom;
            if ($urandom_range(7) != 0) rp[1:0] = 2'b00;
            drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                  $urandom_range(7) == 0, rp);
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_flush();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
